// File: rtl/ysyx_25040109_lsu.sv
// Multi-cycle load/store unit: one word-bus transaction per load/store with lane steering
// and load extension; all other instructions pass straight through to write-back.
module ysyx_25040109_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_reg_write,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd_addr,
  output logic        out_reg_write,
  output logic        out_fault
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  logic [1:0]  state_q;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic        reg_write_q;

  logic        is_load, is_store, legal_f3, misaligned, fault;
  logic [31:0] st_wdata;
  logic [3:0]  st_mask;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  assign in_ready = (state_q == StIdle) && !rst;

  // Decode of the instruction presented this cycle.
  always_comb begin
    is_load  = (in_opcode == OpLoad);
    is_store = (in_opcode == OpStore);
    legal_f3 = 1'b0;
    if (is_load) begin
      legal_f3 = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
                 (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end else if (is_store) begin
      legal_f3 = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end
    misaligned = 1'b0;
    unique case (in_funct3[1:0])
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    fault = (is_load || is_store) && (!legal_f3 || misaligned);

    st_wdata = in_wdata;
    st_mask  = 4'b1111;
    unique case (in_funct3[1:0])
      2'b00: begin
        st_wdata = {4{in_wdata[7:0]}};
        st_mask  = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{in_wdata[15:0]}};
        st_mask  = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: begin
        st_wdata = in_wdata;
        st_mask  = 4'b1111;
      end
    endcase
  end

  // Load formatting uses the latched address offset and size.
  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    ld_data = mem_rdata;
    unique case (funct3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      is_load_q     <= 1'b0;
      funct3_q      <= 3'd0;
      addr_q        <= 32'd0;
      reg_write_q   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'd0;
      mem_wmask     <= 4'd0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_rd_addr   <= 5'd0;
      out_reg_write <= 1'b0;
      out_fault     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            is_load_q   <= is_load;
            funct3_q    <= in_funct3;
            addr_q      <= in_addr;
            reg_write_q <= in_reg_write;
            out_rd_addr <= in_rd_addr;
            if ((is_load || is_store) && !fault) begin
              state_q   <= StReq;
              mem_valid <= 1'b1;
              mem_addr  <= {in_addr[31:2], 2'b00};
              mem_wen   <= is_store;
              mem_wdata <= is_store ? st_wdata : 32'd0;
              mem_wmask <= is_store ? st_mask : 4'd0;
            end else begin
              state_q       <= StDone;
              out_valid     <= 1'b1;
              out_result    <= fault ? 32'd0 : in_addr;
              out_reg_write <= fault ? 1'b0 : in_reg_write;
              out_fault     <= fault;
            end
          end
        end
        StReq: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            state_q       <= StDone;
            out_valid     <= 1'b1;
            out_result    <= is_load_q ? ld_data : addr_q;
            out_reg_write <= is_load_q && reg_write_q;
            out_fault     <= 1'b0;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed self-checking bench for ysyx_25040109_lsu with hand-computed expectations.
module tb_ysyx_25040109_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd_addr;
  logic        in_reg_write;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd_addr;
  logic        out_reg_write;
  logic        out_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25040109_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd_addr   (in_rd_addr),
    .in_reg_write (in_reg_write),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd_addr  (out_rd_addr),
    .out_reg_write(out_reg_write),
    .out_fault    (out_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_addr = addr;
    in_wdata = wd; in_rd_addr = rd; in_reg_write = rw;
    step();
    in_valid = 1'b0;
  endtask

  // Full memory op: optional request stall, one ack cycle, checks bus and result.
  task automatic mem_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [31:0] e_maddr, input logic [3:0] e_mask,
                        input logic [31:0] e_wdata, input logic [31:0] e_res, input logic e_rw,
                        input int stall);
    accept(op, f3, addr, wd, 5'd7, 1'b1);
    for (int i = 0; i <= stall; i++) begin
      check({tag, " mem_valid"}, {31'd0, mem_valid}, 32'd1);
      check({tag, " mem_addr"}, mem_addr, e_maddr);
      check({tag, " mem_wen"}, {31'd0, mem_wen}, {31'd0, op == 7'b0100011});
      check({tag, " mem_wmask"}, {28'd0, mem_wmask}, {28'd0, e_mask});
      if (op == 7'b0100011) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
      if (i < stall) step();
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check({tag, " mem_valid drop"}, {31'd0, mem_valid}, 32'd0);
    check({tag, " wait out_valid"}, {31'd0, out_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'hA5A5A5A5;
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " out_result"}, out_result, e_res);
    check({tag, " out_reg_write"}, {31'd0, out_reg_write}, {31'd0, e_rw});
    check({tag, " out_fault"}, {31'd0, out_fault}, 32'd0);
    check({tag, " out_rd_addr"}, {27'd0, out_rd_addr}, 32'd7);
    step();
    check({tag, " retire"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_addr = '0;
    in_wdata = '0; in_rd_addr = '0; in_reg_write = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b1;
    step(); step();
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset mem_valid", {31'd0, mem_valid}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_result", out_result, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready idle", {31'd0, in_ready}, 32'd1);

    // Pass-through ADD
    accept(7'b0110011, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
    check("pt out_valid", {31'd0, out_valid}, 32'd1);
    check("pt result", out_result, 32'h1234);
    check("pt rd", {27'd0, out_rd_addr}, 32'd5);
    check("pt reg_write", {31'd0, out_reg_write}, 32'd1);
    check("pt fault", {31'd0, out_fault}, 32'd0);
    check("pt mem_valid", {31'd0, mem_valid}, 32'd0);
    check("pt in_ready busy", {31'd0, in_ready}, 32'd0);
    step();
    check("pt retire", {31'd0, out_valid}, 32'd0);

    mem_op("lb", 7'b0000011, 3'b000, 32'h80000003, 0, 32'h80FF7F01, 32'h80000000, 4'b0000, 0,
           32'hFFFFFF80, 1'b1, 0);
    mem_op("lbu", 7'b0000011, 3'b100, 32'h80000003, 0, 32'h80FF7F01, 32'h80000000, 4'b0000, 0,
           32'h00000080, 1'b1, 0);
    mem_op("lh", 7'b0000011, 3'b001, 32'h80000002, 0, 32'h8001ABCD, 32'h80000000, 4'b0000, 0,
           32'hFFFF8001, 1'b1, 0);
    mem_op("lhu", 7'b0000011, 3'b101, 32'h80000002, 0, 32'h8001ABCD, 32'h80000000, 4'b0000, 0,
           32'h00008001, 1'b1, 0);
    mem_op("lb1", 7'b0000011, 3'b000, 32'h80000001, 0, 32'h80FF7F01, 32'h80000000, 4'b0000, 0,
           32'h0000007F, 1'b1, 0);
    mem_op("lw", 7'b0000011, 3'b010, 32'h80000004, 0, 32'h12345678, 32'h80000004, 4'b0000, 0,
           32'h12345678, 1'b1, 0);
    mem_op("sb", 7'b0100011, 3'b000, 32'h80000001, 32'hDEADBEEF, 32'h0, 32'h80000000, 4'b0010,
           32'hEFEFEFEF, 32'h80000001, 1'b0, 0);
    mem_op("sh", 7'b0100011, 3'b001, 32'h80000002, 32'hDEADBEEF, 32'h0, 32'h80000000, 4'b1100,
           32'hBEEFBEEF, 32'h80000002, 1'b0, 0);
    // Request stalled three cycles; bus signals must hold.
    mem_op("sw stall", 7'b0100011, 3'b010, 32'h80000008, 32'hDEADBEEF, 32'h0, 32'h80000008,
           4'b1111, 32'hDEADBEEF, 32'h80000008, 1'b0, 3);

    // Misaligned LW faults without a bus request
    accept(7'b0000011, 3'b010, 32'h80000002, 0, 5'd9, 1'b1);
    check("mis mem_valid", {31'd0, mem_valid}, 32'd0);
    check("mis out_valid", {31'd0, out_valid}, 32'd1);
    check("mis fault", {31'd0, out_fault}, 32'd1);
    check("mis reg_write", {31'd0, out_reg_write}, 32'd0);
    check("mis result", out_result, 32'd0);
    step();

    // Illegal funct3 on store
    accept(7'b0100011, 3'b100, 32'h80000000, 0, 5'd9, 1'b1);
    check("ill mem_valid", {31'd0, mem_valid}, 32'd0);
    check("ill fault", {31'd0, out_fault}, 32'd1);
    step();

    // Backpressure: DONE held with stable outputs
    out_ready = 1'b0;
    accept(7'b0010011, 3'b000, 32'hCAFE0001, 0, 5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp result", out_result, 32'hCAFE0001);
      check("bp rd", {27'd0, out_rd_addr}, 32'd3);
      check("bp reg_write", {31'd0, out_reg_write}, 32'd0);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    step();
    check("bp release", {31'd0, out_valid}, 32'd0);

    // Reset during WAIT abandons the op
    accept(7'b0000011, 3'b010, 32'h80000010, 0, 5'd4, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_rd", {27'd0, out_rd_addr}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_rvalid = 1'b0;
    check("stale rvalid out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("stale rvalid out_valid 2", {31'd0, out_valid}, 32'd0);
    check("post rst in_ready", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
